regfile_wb_scheduler: RTL and testbench

//   Shares the single register-file write port (we3/a3/wd3) between NUM_REQ

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 42 ++++
 rtl/regfile_wb_scheduler.sv | 108 ++++++++++
 tb/tb_regfile_wb_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared constants and helpers for the register-file write-back scheduler.
//   XLEN        : data width of a register.
//   REG_ADDR_W  : register address width.
//   NUM_REGS    : number of architectural registers (and scoreboard entries).
//   ZERO_REG    : hard-wired zero register; never written, never pending.
//   ptr_width() : width of a round-robin pointer over n requesters.
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  // Pointer width for n requesters, never less than one bit.
  function automatic int ptr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : regfile_pkg

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin arbiter. The search starts at lane ptr and wraps
//   modulo N; the first requesting lane wins.
//   Ports:
//     req     in  [N-1:0]   request per lane
//     ptr     in  [PW-1:0]  lane with highest priority this cycle
//     gnt     out [N-1:0]   one-hot grant (all zero when nothing requests)
//     gnt_idx out [PW-1:0]  index of the granted lane (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  always_comb begin : search
    logic found;
    int   idx;
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler
//   Shares the single register-file write port between NUM_REQ write-back
//   requesters with round-robin arbitration, and keeps a pending-write
//   scoreboard that flags read-after-write hazards for the issue stage.
//   Ports:
//     clk, reset   clock; synchronous active-high reset
//     issue_valid  issue stage allocates destination issue_rd
//     issue_rd     destination being allocated
//     issue_ready  allocation accepted this cycle
//     req_valid    write-back request per lane
//     req_addr     packed destination per lane, lane i = [i*REG_ADDR_W +: REG_ADDR_W]
//     req_data     packed data per lane, lane i = [i*XLEN +: XLEN]
//     req_ready    one-hot grant; transfer = valid & ready
//     we3/a3/wd3   registered write port towards register_file
//     rs1, rs2     source registers of the instruction at issue
//     hazard       rs1 or rs2 has a pending write
//     pending      scoreboard, bit r set while register r awaits write-back
// -----------------------------------------------------------------------------
module regfile_wb_scheduler #(
  parameter int NUM_REQ    = 2,
  parameter int XLEN       = regfile_pkg::XLEN,
  parameter int REG_ADDR_W = regfile_pkg::REG_ADDR_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  output logic                          issue_ready,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          we3,
  output logic [REG_ADDR_W-1:0]         a3,
  output logic [XLEN-1:0]               wd3,
  input  logic [REG_ADDR_W-1:0]         rs1,
  input  logic [REG_ADDR_W-1:0]         rs2,
  output logic                          hazard,
  output logic [regfile_pkg::NUM_REGS-1:0] pending
);

  import regfile_pkg::*;

  localparam int PW = ptr_width(NUM_REQ);

  logic [PW-1:0]         rr_ptr;
  logic [NUM_REQ-1:0]    gnt;
  logic [PW-1:0]         gnt_idx;
  logic                  grant;
  logic [REG_ADDR_W-1:0] win_addr;
  logic [XLEN-1:0]       win_data;
  logic                  issue_fire;
  logic [NUM_REGS-1:0]   pending_next;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Nothing is consumed while reset is high.
  assign req_ready = reset ? '0 : gnt;
  assign grant     = |req_ready;
  assign win_addr  = req_addr[gnt_idx*REG_ADDR_W +: REG_ADDR_W];
  assign win_data  = req_data[gnt_idx*XLEN +: XLEN];

  // A still-pending destination stalls allocation, which rules out WAW.
  assign issue_ready = !reset && ((issue_rd == ZERO_REG) || !pending[issue_rd]);
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != ZERO_REG);

  // No bypass: a source stays hazardous until its write has committed.
  assign hazard = ((rs1 != ZERO_REG) && pending[rs1]) ||
                  ((rs2 != ZERO_REG) && pending[rs2]);

  // Clear and set never target the same register in one cycle: a set needs
  // the bit clear, a clear needs it set.
  always_comb begin
    pending_next = pending;
    if (we3)        pending_next[a3]       = 1'b0;
    if (issue_fire) pending_next[issue_rd] = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      rr_ptr  <= '0;
      we3     <= 1'b0;
      a3      <= '0;
      wd3     <= '0;
    end else begin
      pending <= pending_next;
      if (grant) begin
        rr_ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        a3     <= win_addr;
        wd3    <= win_data;
        // Writes to x0 are consumed but never reach the register file.
        we3    <= (win_addr != ZERO_REG);
      end else begin
        we3 <= 1'b0;
      end
    end
  end

endmodule : regfile_wb_scheduler

// File: tb/tb_regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_scheduler
//   Directed bench for regfile_wb_scheduler with NUM_REQ=2. A behavioural
//   register file sits on we3/a3/wd3 so committed values can be checked.
//   Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;
  localparam int AW      = 5;

  logic                  clk;
  logic                  reset;
  logic                  issue_valid;
  logic [AW-1:0]         issue_rd;
  logic                  issue_ready;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*XLEN-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  we3;
  logic [AW-1:0]         a3;
  logic [XLEN-1:0]       wd3;
  logic [AW-1:0]         rs1;
  logic [AW-1:0]         rs2;
  logic                  hazard;
  logic [31:0]           pending;

  int errors = 0;
  int checks = 0;

  logic [XLEN-1:0] rf [32];

  regfile_wb_scheduler #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .REG_ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .we3         (we3),
    .a3          (a3),
    .wd3         (wd3),
    .rs1         (rs1),
    .rs2         (rs2),
    .hazard      (hazard),
    .pending     (pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file model: commits the write port at the rising edge.
  always @(posedge clk) begin
    if (we3) rf[a3] <= wd3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [AW-1:0] addr,
                          input logic [XLEN-1:0] data);
    req_addr[lane*AW +: AW]     = addr;
    req_data[lane*XLEN +: XLEN] = data;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    req_valid   = 2'b11;
    issue_valid = 1'b1;
    issue_rd    = 5'd1;
    set_lane(0, 5'd3, 32'h0000_0030);
    set_lane(1, 5'd4, 32'h0000_0040);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (req_ready !== 2'b00) begin
        errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready);
      end
      checks++;
      if (issue_ready !== 1'b0) begin
        errors++; $display("FAIL reset_issue_ready got=%b exp=0", issue_ready);
      end
    end
    checks++;
    if (we3 !== 1'b0 || a3 !== 5'd0 || wd3 !== 32'd0) begin
      errors++; $display("FAIL reset_port got we3=%b a3=%0d wd3=%h exp 0/0/0", we3, a3, wd3);
    end
    checks++;
    if (pending !== 32'd0) begin
      errors++; $display("FAIL reset_pending got=%h exp=0", pending);
    end
    req_valid   = 2'b00;
    issue_valid = 1'b0;
    reset       = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0]    exp_gnt;
    logic [AW-1:0] exp_a3;
    set_lane(0, 5'd3, 32'h0000_0030);
    set_lane(1, 5'd4, 32'h0000_0040);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_a3  = (i % 2 == 0) ? 5'd3 : 5'd4;
      #1;
      checks++;
      if (req_ready !== exp_gnt) begin
        errors++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, req_ready, exp_gnt);
      end
      tick();
      checks++;
      if (we3 !== 1'b1 || a3 !== exp_a3) begin
        errors++; $display("FAIL rr_a3[%0d] got we3=%b a3=%0d exp we3=1 a3=%0d", i, we3, a3, exp_a3);
      end
    end
    req_valid = 2'b00;
    tick();
    checks++;
    if (we3 !== 1'b0 || rf[3] !== 32'h30 || rf[4] !== 32'h40) begin
      errors++; $display("FAIL rr_idle got we3=%b r3=%h r4=%h exp 0/30/40", we3, rf[3], rf[4]);
    end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++; $display("FAIL sb_issue_ready got=%b exp=1", issue_ready);
    end
    tick();
    issue_valid = 1'b0;
    rs1 = 5'd7;
    #1;
    checks++;
    if (pending !== 32'h0000_0080 || hazard !== 1'b1) begin
      errors++; $display("FAIL sb_set got pending=%h hazard=%b exp 00000080/1", pending, hazard);
    end
    set_lane(1, 5'd7, 32'hDEAD_BEEF);
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL sb_grant got=%b exp=10", req_ready);
    end
    tick();
    req_valid = 2'b00;
    checks++;
    if (we3 !== 1'b1 || a3 !== 5'd7 || wd3 !== 32'hDEAD_BEEF || hazard !== 1'b1) begin
      errors++; $display("FAIL sb_we3 got we3=%b a3=%0d wd3=%h hazard=%b exp 1/7/deadbeef/1", we3, a3, wd3, hazard);
    end
    tick();
    checks++;
    if (we3 !== 1'b0 || hazard !== 1'b0 || pending !== 32'd0) begin
      errors++; $display("FAIL sb_clear got we3=%b hazard=%b pending=%h exp 0/0/0", we3, hazard, pending);
    end
    checks++;
    if (rf[7] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sb_rf7 got=%h exp=deadbeef", rf[7]);
    end
    rs1 = 5'd0;
  endtask

  task automatic test_waw_stall();
    // rr_ptr is 0 here: the last grant went to lane 1.
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    tick();
    checks++;
    if (issue_ready !== 1'b0 || pending[5] !== 1'b1) begin
      errors++; $display("FAIL waw_stall got ready=%b pend5=%b exp 0/1", issue_ready, pending[5]);
    end
    set_lane(0, 5'd5, 32'h0000_0555);
    req_valid = 2'b01;
    #1;
    checks++;
    if (req_ready !== 2'b01 || issue_ready !== 1'b0) begin
      errors++; $display("FAIL waw_grant got gnt=%b ready=%b exp 01/0", req_ready, issue_ready);
    end
    tick();
    req_valid = 2'b00;
    checks++;
    if (we3 !== 1'b1 || issue_ready !== 1'b0) begin
      errors++; $display("FAIL waw_commit_cycle got we3=%b ready=%b exp 1/0", we3, issue_ready);
    end
    tick();
    checks++;
    if (pending[5] !== 1'b0 || issue_ready !== 1'b1) begin
      errors++; $display("FAIL waw_release got pend5=%b ready=%b exp 0/1", pending[5], issue_ready);
    end
    tick();
    issue_valid = 1'b0;
    checks++;
    if (pending !== 32'h0000_0020) begin
      errors++; $display("FAIL waw_realloc got pending=%h exp=00000020", pending);
    end
    // Drain r5 through lane 1 (rr_ptr now 1).
    set_lane(1, 5'd5, 32'h0000_0556);
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    tick();
    checks++;
    if (pending !== 32'd0 || rf[5] !== 32'h556) begin
      errors++; $display("FAIL waw_drain got pending=%h r5=%h exp 0/556", pending, rf[5]);
    end
  endtask

  task automatic test_x0();
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++; $display("FAIL x0_issue_ready got=%b exp=1", issue_ready);
    end
    tick();
    issue_valid = 1'b0;
    checks++;
    if (pending !== 32'd0) begin
      errors++; $display("FAIL x0_pending got=%h exp=0", pending);
    end
    // rr_ptr is 0 here.
    set_lane(0, 5'd0, 32'h0000_1234);
    req_valid = 2'b01;
    rs1 = 5'd0;
    rs2 = 5'd0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL x0_grant got=%b exp=01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    checks++;
    if (we3 !== 1'b0 || hazard !== 1'b0) begin
      errors++; $display("FAIL x0_we3 got we3=%b hazard=%b exp 0/0", we3, hazard);
    end
  endtask

  task automatic test_reset_midflight();
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    issue_valid = 1'b0;
    // rr_ptr is 1 after the x0 grant on lane 0.
    set_lane(1, 5'd9, 32'h0000_0099);
    req_valid = 2'b10;
    #1;
    checks++;
    if (req_ready !== 2'b10 || pending !== 32'h0000_0200) begin
      errors++; $display("FAIL mid_grant got gnt=%b pending=%h exp 10/00000200", req_ready, pending);
    end
    tick();
    checks++;
    if (we3 !== 1'b1 || a3 !== 5'd9) begin
      errors++; $display("FAIL mid_we3 got we3=%b a3=%0d exp 1/9", we3, a3);
    end
    reset     = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++; $display("FAIL mid_req_ready got=%b exp=00", req_ready);
    end
    tick();
    checks++;
    if (rf[9] !== 32'h99 || pending !== 32'd0 || we3 !== 1'b0) begin
      errors++; $display("FAIL mid_after got r9=%h pending=%h we3=%b exp 99/0/0", rf[9], pending, we3);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL mid_ptr_reset got=%b exp=01", req_ready);
    end
    req_valid = 2'b00;
    tick();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_rd    = '0;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    rs1         = '0;
    rs2         = '0;
    #1;
    test_reset();
    test_round_robin();
    test_scoreboard();
    test_waw_stall();
    test_x0();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_regfile_wb_scheduler
